serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx_if.sv | 22 ++
 rtl/serial_tx.sv | 121 ++++++++++++
 tb/tb_serial_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_tx_if.sv
// Parallel-in / serial-out transmitter bundle.
// The master drives the word and request; the slave drives line and status.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              send;
    logic              ready;
    logic              busy;
    logic              tx;
    logic              done;

    modport master (
        output data, send,
        input  ready, busy, tx, done
    );

    modport slave (
        input  data, send,
        output ready, busy, tx, done
    );
endinterface

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit, LSB-first data,
// optional even parity, stop bit, each CLKS_PER_BIT cycles long.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic clk,
    input  logic reset,
    serial_tx_if.slave bus
);
    localparam int NB = DATA_W + PARITY_EN;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              last;

    assign last = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.send) begin
                    state_d = START;
                    sh_d    = bus.data;
                    par_d   = ^bus.data;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    tx_d    = sh_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (!last) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (bit_q == BW'(NB - 1)) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        // past the last data bit the parity period follows
                        if (bit_q < BW'(DATA_W - 1)) begin
                            sh_d = sh_q >> 1;
                            tx_d = sh_q[1];
                        end else begin
                            tx_d = par_q;
                        end
                    end
                end
            end
            STOP: begin
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q != IDLE);
    assign bus.tx    = tx_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx across four parameter sets,
// compared against a bit-period model of the serial frame.
module tb_serial_tx;
    localparam int DW_L [4]  = '{8, 8, 8, 5};
    localparam int CPB_L [4] = '{4, 4, 1, 3};
    localparam int PAR_L [4] = '{0, 1, 0, 1};

    logic       clk;
    logic [3:0] rst_r;
    logic [3:0] send_r;
    logic [7:0] data_r [4];
    logic [3:0] tx_w, ready_w, busy_w, done_w;

    int checks = 0;
    int errors = 0;

    serial_tx_if #(.DATA_W(8)) ia ();
    serial_tx_if #(.DATA_W(8)) ib ();
    serial_tx_if #(.DATA_W(8)) ic ();
    serial_tx_if #(.DATA_W(5)) id ();

    assign ia.send = send_r[0];
    assign ib.send = send_r[1];
    assign ic.send = send_r[2];
    assign id.send = send_r[3];
    assign ia.data = data_r[0];
    assign ib.data = data_r[1];
    assign ic.data = data_r[2];
    assign id.data = data_r[3][4:0];

    assign tx_w    = {id.tx, ic.tx, ib.tx, ia.tx};
    assign ready_w = {id.ready, ic.ready, ib.ready, ia.ready};
    assign busy_w  = {id.busy, ic.busy, ib.busy, ia.busy};
    assign done_w  = {id.done, ic.done, ib.done, ia.done};

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_a (
        .clk(clk), .reset(rst_r[0]), .bus(ia)
    );
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_b (
        .clk(clk), .reset(rst_r[1]), .bus(ib)
    );
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_c (
        .clk(clk), .reset(rst_r[2]), .bus(ic)
    );
    serial_tx #(.DATA_W(5), .CLKS_PER_BIT(3), .PARITY_EN(1)) u_d (
        .clk(clk), .reset(rst_r[3]), .bus(id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // line level in cycle k after the accept edge
    function automatic int exp_bit(input int l, input logic [7:0] w,
                                   input int k);
        int b;
        int p;
        b = k / CPB_L[l];
        p = 0;
        for (int i = 0; i < DW_L[l]; i++) p = p ^ int'(w[i]);
        if (b == 0) return 0;
        if (b <= DW_L[l]) return int'(w[b-1]);
        if (PAR_L[l] == 1 && b == DW_L[l] + 1) return p;
        return 1;
    endfunction

    task automatic idle_chk(input int l, input string tag);
        check($sformatf("L%0d %s tx", l, tag), int'(tx_w[l]), 1);
        check($sformatf("L%0d %s ready", l, tag), int'(ready_w[l]), 1);
        check($sformatf("L%0d %s busy", l, tag), int'(busy_w[l]), 0);
        check($sformatf("L%0d %s done", l, tag), int'(done_w[l]), 0);
    endtask

    task automatic frame(input int l, input logic [7:0] w, input bit pre,
                         input bit noise, input int abort_at,
                         input bit chain, input logic [7:0] nxt);
        int len;
        len = (2 + DW_L[l] + PAR_L[l]) * CPB_L[l];
        if (!pre) begin
            @(negedge clk);
            data_r[l] = w;
            send_r[l] = 1'b1;
        end
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            send_r[l] = noise && (k == 10);
            if (noise) data_r[l] = 8'($urandom);
            if (k == abort_at) begin
                #2 rst_r[l] = 1'b1;
                #1 idle_chk(l, "abort");
                return;
            end
            check($sformatf("L%0d w%0h k%0d tx", l, w, k),
                  int'(tx_w[l]), exp_bit(l, w, k));
            check($sformatf("L%0d k%0d ready", l, k), int'(ready_w[l]), 0);
            check($sformatf("L%0d k%0d busy", l, k), int'(busy_w[l]), 1);
            check($sformatf("L%0d k%0d done", l, k), int'(done_w[l]), 0);
        end
        @(negedge clk);
        check($sformatf("L%0d w%0h end done", l, w), int'(done_w[l]), 1);
        check($sformatf("L%0d end ready", l), int'(ready_w[l]), 1);
        check($sformatf("L%0d end busy", l), int'(busy_w[l]), 0);
        check($sformatf("L%0d end tx", l), int'(tx_w[l]), 1);
        if (chain) begin
            data_r[l] = nxt;
            send_r[l] = 1'b1;
        end else begin
            send_r[l] = 1'b0;
        end
    endtask

    task automatic random_frames(input int l, input int n);
        logic [7:0] w;
        logic [7:0] nxt;
        bit         pre;
        bit         ch;
        pre = 1'b0;
        w   = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            nxt = 8'($urandom);
            ch  = (i < n - 1) && ($urandom_range(0, 1) == 1);
            frame(l, w, pre, $urandom_range(0, 3) == 0, -1, ch, nxt);
            pre = ch;
            w   = ch ? nxt : 8'($urandom);
        end
    endtask

    initial begin
        rst_r  = 4'hF;
        send_r = 4'h0;
        for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) idle_chk(i, "reset");
        rst_r = 4'h0;

        frame(0, 8'hA5, 1'b0, 1'b0, -1, 1'b0, 8'h00);
        frame(0, 8'h3C, 1'b0, 1'b1, -1, 1'b0, 8'h00);
        frame(0, 8'h01, 1'b0, 1'b0, -1, 1'b1, 8'h80);
        frame(0, 8'h80, 1'b1, 1'b0, -1, 1'b0, 8'h00);
        frame(0, 8'h11, 1'b0, 1'b0, 17, 1'b0, 8'h00);
        data_r[0] = 8'hFF;
        send_r[0] = 1'b1;
        @(posedge clk);
        #1 idle_chk(0, "held");
        rst_r[0]  = 1'b0;
        send_r[0] = 1'b0;
        frame(0, 8'h55, 1'b0, 1'b0, -1, 1'b0, 8'h00);
        random_frames(0, 6);

        frame(1, 8'h07, 1'b0, 1'b0, -1, 1'b0, 8'h00);
        frame(1, 8'h03, 1'b0, 1'b0, -1, 1'b0, 8'h00);
        random_frames(1, 6);

        frame(2, 8'hF0, 1'b0, 1'b0, -1, 1'b0, 8'h00);
        random_frames(2, 10);

        random_frames(3, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
